// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment driver: segment font, blank pattern and
// the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG7_OFF = 7'b000_0000;

  // Segment order is {g,f,e,d,c,b,a}; entries 0-9 then A, b, C, d, E, F.
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational hex nibble to 7-segment pattern lookup.
module seg7_font_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_FONT[nibble_i];

endmodule

// File: rtl/seg7_mux_driver.sv
// Double-buffered, time-multiplexed NUM_DIGITS 7-segment display driver.
// Define SEG7_MUX_DP_EN to add the per-digit decimal point path (dp_in/dp_out).
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_lz_in,
  output logic [6:0]              segments_out,
  output logic [NUM_DIGITS-1:0]   digit_en_out,
  output logic                    frame_done
`ifdef SEG7_MUX_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp_out
`endif
);

  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG7_OFF : SEG7_OFF;
  localparam logic [NUM_DIGITS-1:0] EN_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // lz[k] set when blanking is on, k is not the rightmost digit, and every
  // nibble from k up to the most significant one is zero.
  function automatic logic [NUM_DIGITS-1:0] calc_lz(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic blank);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (v[4*k +: 4] == 4'h0);
      m[k]     = blank && (k != 0) && zero_run;
    end
    return m;
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0]   lz_q, lz_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fdone_q, fdone_d;

  logic                    last_cnt, boundary, gap, load;
  logic [3:0]              nib;
  logic                    lz_sel;
  logic [6:0]              font_seg, seg_raw;
  logic [NUM_DIGITS-1:0]   en_raw;

`ifdef SEG7_MUX_DP_EN
  logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
  logic [NUM_DIGITS-1:0]   dp_pend_q, dp_pend_d;
  logic                    dp_q, dp_d, dp_sel;
`endif

  assign last_cnt    = (cnt_q == CNT_LAST);
  assign boundary    = last_cnt && (idx_q == IDX_LAST);
  assign gap         = (cnt_q == '0);
  assign load        = value_valid && !pend_full_q;
  assign value_ready = !pend_full_q;

  always_comb begin
    nib    = 4'h0;
    lz_sel = 1'b0;
`ifdef SEG7_MUX_DP_EN
    dp_sel = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib    = disp_q[4*k +: 4];
        lz_sel = lz_q[k];
`ifdef SEG7_MUX_DP_EN
        dp_sel = dp_disp_q[k];
`endif
      end
    end
  end

  seg7_font_rom u_font (
    .nibble_i (nib),
    .seg_o    (font_seg)
  );

  always_comb begin
    cnt_d       = last_cnt ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    if (last_cnt) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) begin
      pend_d      = value_in;
      pend_full_d = 1'b1;
    end else if (boundary) begin
      pend_full_d = 1'b0;
    end

    disp_d = (boundary && pend_full_q) ? pend_q : disp_q;
    lz_d   = boundary ? calc_lz(disp_d, blank_lz_in) : lz_q;

`ifdef SEG7_MUX_DP_EN
    dp_pend_d = load ? dp_in : dp_pend_q;
    dp_disp_d = (boundary && pend_full_q) ? dp_pend_q : dp_disp_q;
    dp_d      = (gap ? 1'b0 : dp_sel) ^ (SEG_ACTIVE_LOW != 0);
`endif

    // Pin stage: slot at count 0 is the anti-ghost gap with every digit off.
    seg_raw = (gap || lz_sel) ? SEG7_OFF : font_seg;
    en_raw  = gap ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    en_d    = (DIG_ACTIVE_LOW != 0) ? ~en_raw : en_raw;
    fdone_d = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      lz_q        <= '0;
      seg_q       <= SEG_IDLE;
      en_q        <= EN_IDLE;
      fdone_q     <= 1'b0;
`ifdef SEG7_MUX_DP_EN
      dp_disp_q   <= '0;
      dp_pend_q   <= '0;
      dp_q        <= (SEG_ACTIVE_LOW != 0);
`endif
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      lz_q        <= lz_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
      fdone_q     <= fdone_d;
`ifdef SEG7_MUX_DP_EN
      dp_disp_q   <= dp_disp_d;
      dp_pend_q   <= dp_pend_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign segments_out = seg_q;
  assign digit_en_out = en_q;
  assign frame_done   = fdone_q;
`ifdef SEG7_MUX_DP_EN
  assign dp_out       = dp_q;
`endif

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver (4 digits, 4 clocks per slot, active-high pins).
module tb_seg7_mux_driver;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int FR = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        blank_lz_in = 1'b0;
  logic [6:0]  segments_out;
  logic [3:0]  digit_en_out;
  logic        frame_done;
  logic [3:0]  dp_in = '0;
`ifdef SEG7_MUX_DP_EN
  logic        dp_out;
`endif

  seg7_mux_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
    .clk          (clk),
    .reset        (rst),
    .value_in     (value_in),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .blank_lz_in  (blank_lz_in),
    .segments_out (segments_out),
    .digit_en_out (digit_en_out),
    .frame_done   (frame_done)
`ifdef SEG7_MUX_DP_EN
    ,
    .dp_in        (dp_in),
    .dp_out       (dp_out)
`endif
  );

  always #5 clk = ~clk;

  // Standard hex font, segments {g,f,e,d,c,b,a}.
  logic [6:0] FONT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    int          stamp;
  } ent_t;

  ent_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic [15:0] m_disp = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_lz = '0;
  bit          prev_blank = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Leading-zero mask: every digit above the highest nonzero one is blanked.
  function automatic logic [3:0] lz_of(input logic [15:0] v, input bit b);
    int h = 0;
    logic [3:0] r = '0;
    for (int k = 0; k < N; k++)
      if (((v >> (4 * k)) & 16'hF) != 0) h = k;
    for (int k = 0; k < N; k++) r[k] = b && (k > h);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: pin k reflects the scan position reached after k-1 clocks.
  always @(negedge clk) begin
    int st, cnt, idx, nibv;
    bit full;
    if (mon_en) begin
      if (rst || cyc == 0) begin
        chk("idle_seg", 32'(segments_out), 32'h0);
        chk("idle_en", 32'(digit_en_out), 32'h0);
        chk("idle_fd", 32'(frame_done), 32'h0);
        chk("idle_rdy", 32'(value_ready), 32'h1);
        if (rst) begin
          sb_q.delete();
          m_disp = '0;
          m_dp   = '0;
          m_lz   = '0;
        end
      end else begin
        st  = cyc - 1;
        cnt = st % S;
        idx = (st / S) % N;
        chk("digit_en", 32'(digit_en_out), (cnt == 0) ? 32'h0 : (32'h1 << idx));
        if (cnt != 0) begin
          nibv = int'((m_disp >> (4 * idx)) & 16'hF);
          chk("segments", 32'(segments_out), m_lz[idx] ? 32'h0 : 32'(FONT[nibv]));
`ifdef SEG7_MUX_DP_EN
          chk("dp", 32'(dp_out), 32'(m_dp[idx]));
`endif
        end
        chk("frame_done", 32'(frame_done), 32'((cyc % FR) == 0));
        if ((cyc % FR) == 0) begin
          if (sb_q.size() > 0 && sb_q[0].stamp < cyc) begin
            m_disp = sb_q[0].v;
            m_dp   = sb_q[0].dp;
            void'(sb_q.pop_front());
          end
          m_lz = lz_of(m_disp, prev_blank);
        end
        full = (sb_q.size() > 0) && (sb_q[0].stamp <= cyc);
        chk("ready", 32'(value_ready), 32'(!full));
      end
    end
    prev_blank = blank_lz_in;
  end

  // Offer a value and hold it until the handshake completes.
  task automatic offer(input logic [15:0] v, input logic [3:0] dp);
    ent_t e;
    bit   done = 1'b0;
    value_in    = v;
    dp_in       = dp;
    value_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (value_ready) begin
        e.v = v; e.dp = dp; e.stamp = cyc + 1;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("handshake_timeout", 32'h0, 32'h1);
    value_valid = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n * FR) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rv;
    #2 rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    offer(16'h1234, 4'b0010);
    frames(3);

    blank_lz_in = 1'b1;
    offer(16'h0050, 4'b1001);
    frames(3);
    offer(16'h0000, 4'b0100);
    frames(3);

    blank_lz_in = 1'b0;
    offer(16'hAAAA, 4'b0011);
    offer(16'hBBBB, 4'b1100);
    frames(3);

    for (int i = 0; i < 25; i++) begin
      blank_lz_in = 1'($urandom_range(0, 1));
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv = rv >> (4 * $urandom_range(1, 4));
      offer(rv, 4'($urandom));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    frames(3);

    offer(16'h9876, 4'b1111);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_seg", 32'(segments_out), 32'h0);
    chk("rst_async_en", 32'(digit_en_out), 32'h0);
    chk("rst_async_rdy", 32'(value_ready), 32'h1);
    chk("rst_async_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
